// File: rtl/trig_lut_arbiter.sv
// Round-robin arbiter sharing one 45-entry sin/cos magnitude ROM among NUM_REQ requesters.
// Optional TRIG_SIGNED_EN: outputs two's complement components instead of zero-extended magnitudes.
module trig_lut_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [6*NUM_REQ-1:0] req_angle,
    output logic [NUM_REQ-1:0]   req_gnt,
    output logic                 resp_valid,
    output logic [ID_W-1:0]      resp_id,
    output logic [8:0]           resp_sin,
    output logic [8:0]           resp_cos,
    output logic                 resp_sin_neg,
    output logic                 resp_cos_neg
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned ANG_W = 6;
    localparam int unsigned MAG_W = 5;
    localparam int unsigned OUT_W = 9;
    localparam logic [ANG_W-1:0] NUM_ANG = 6'd45;

    // Entry k = {round(16|sin(8k deg)|), round(16|cos(8k deg)|)}
    function automatic logic [2*MAG_W-1:0] trig_rom(input logic [ANG_W-1:0] k);
        case (k)
            6'd0:  trig_rom = {5'd0,  5'd16};  6'd1:  trig_rom = {5'd2,  5'd16};
            6'd2:  trig_rom = {5'd4,  5'd15};  6'd3:  trig_rom = {5'd7,  5'd15};
            6'd4:  trig_rom = {5'd8,  5'd14};  6'd5:  trig_rom = {5'd10, 5'd12};
            6'd6:  trig_rom = {5'd12, 5'd11};  6'd7:  trig_rom = {5'd13, 5'd9};
            6'd8:  trig_rom = {5'd14, 5'd7};   6'd9:  trig_rom = {5'd15, 5'd5};
            6'd10: trig_rom = {5'd16, 5'd3};   6'd11: trig_rom = {5'd16, 5'd1};
            6'd12: trig_rom = {5'd16, 5'd2};   6'd13: trig_rom = {5'd16, 5'd4};
            6'd14: trig_rom = {5'd15, 5'd6};   6'd15: trig_rom = {5'd14, 5'd8};
            6'd16: trig_rom = {5'd13, 5'd10};  6'd17: trig_rom = {5'd11, 5'd12};
            6'd18: trig_rom = {5'd9,  5'd13};  6'd19: trig_rom = {5'd8,  5'd14};
            6'd20: trig_rom = {5'd5,  5'd15};  6'd21: trig_rom = {5'd3,  5'd16};
            6'd22: trig_rom = {5'd1,  5'd16};  6'd23: trig_rom = {5'd1,  5'd16};
            6'd24: trig_rom = {5'd3,  5'd16};  6'd25: trig_rom = {5'd5,  5'd15};
            6'd26: trig_rom = {5'd8,  5'd14};  6'd27: trig_rom = {5'd9,  5'd13};
            6'd28: trig_rom = {5'd11, 5'd12};  6'd29: trig_rom = {5'd13, 5'd10};
            6'd30: trig_rom = {5'd14, 5'd8};   6'd31: trig_rom = {5'd15, 5'd6};
            6'd32: trig_rom = {5'd16, 5'd4};   6'd33: trig_rom = {5'd16, 5'd2};
            6'd34: trig_rom = {5'd16, 5'd1};   6'd35: trig_rom = {5'd16, 5'd3};
            6'd36: trig_rom = {5'd15, 5'd5};   6'd37: trig_rom = {5'd14, 5'd7};
            6'd38: trig_rom = {5'd13, 5'd9};   6'd39: trig_rom = {5'd12, 5'd11};
            6'd40: trig_rom = {5'd10, 5'd12};  6'd41: trig_rom = {5'd8,  5'd14};
            6'd42: trig_rom = {5'd7,  5'd15};  6'd43: trig_rom = {5'd4,  5'd15};
            6'd44: trig_rom = {5'd2,  5'd16};
            default: trig_rom = '0;
        endcase
    endfunction

    logic [ANG_W-1:0] angle_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_angle
        assign angle_arr[g] = req_angle[ANG_W*g +: ANG_W];
    end

    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               s1_valid_q;
    logic [IDX_W-1:0]   s1_id_q;
    logic [ANG_W-1:0]   s1_angle_q;

    logic               gnt_found_c;
    logic [IDX_W-1:0]   gnt_idx_c;
    logic [IDX_W-1:0]   cand_c;
    logic [NUM_REQ-1:0] gnt_vec_c;
    logic [ANG_W-1:0]   angle_sel_c;
    logic [ANG_W-1:0]   angle_red_c;

    // S0: first asserted requester at or after rr_ptr wins
    always_comb begin
        gnt_found_c = 1'b0;
        gnt_idx_c   = '0;
        cand_c      = '0;
        gnt_vec_c   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand_c = IDX_W'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!gnt_found_c && req_valid[cand_c]) begin
                gnt_found_c = 1'b1;
                gnt_idx_c   = cand_c;
            end
        end
        if (gnt_found_c) begin
            gnt_vec_c[gnt_idx_c] = 1'b1;
        end
        rr_ptr_d    = (gnt_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_c + IDX_W'(1);
        angle_sel_c = angle_arr[gnt_idx_c];
        angle_red_c = (angle_sel_c >= NUM_ANG) ? angle_sel_c - NUM_ANG : angle_sel_c;
    end

    logic [2*MAG_W-1:0] rom_c;
    logic               sin_neg_c, cos_neg_c;
    logic [OUT_W-1:0]   sin_ext_c, cos_ext_c, sin_val_c, cos_val_c;

    // S1: ROM read and quadrant sign decode
    assign rom_c     = trig_rom(s1_angle_q);
    assign sin_neg_c = (s1_angle_q >= 6'd23);
    assign cos_neg_c = (s1_angle_q >= 6'd12) && (s1_angle_q <= 6'd33);
    assign sin_ext_c = OUT_W'(rom_c[2*MAG_W-1:MAG_W]);
    assign cos_ext_c = OUT_W'(rom_c[MAG_W-1:0]);

`ifdef TRIG_SIGNED_EN
    assign sin_val_c = sin_neg_c ? OUT_W'(0) - sin_ext_c : sin_ext_c;
    assign cos_val_c = cos_neg_c ? OUT_W'(0) - cos_ext_c : cos_ext_c;
`else
    assign sin_val_c = sin_ext_c;
    assign cos_val_c = cos_ext_c;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rr_ptr_q     <= '0;
            req_gnt      <= '0;
            s1_valid_q   <= 1'b0;
            s1_id_q      <= '0;
            s1_angle_q   <= '0;
            resp_valid   <= 1'b0;
            resp_id      <= '0;
            resp_sin     <= '0;
            resp_cos     <= '0;
            resp_sin_neg <= 1'b0;
            resp_cos_neg <= 1'b0;
        end else begin
            req_gnt    <= gnt_vec_c;
            s1_valid_q <= gnt_found_c;
            if (gnt_found_c) begin
                rr_ptr_q   <= rr_ptr_d;
                s1_id_q    <= gnt_idx_c;
                s1_angle_q <= angle_red_c;
            end
            resp_valid <= s1_valid_q;
            // Response data holds between valid pulses
            if (s1_valid_q) begin
                resp_id      <= ID_W'(s1_id_q);
                resp_sin     <= sin_val_c;
                resp_cos     <= cos_val_c;
                resp_sin_neg <= sin_neg_c;
                resp_cos_neg <= cos_neg_c;
            end
        end
    end

endmodule

// File: tb/tb_trig_lut_arbiter.sv
// Self-checking bench for trig_lut_arbiter: vector table, fairness, random traffic and mid-pipeline reset.
module tb_trig_lut_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [3:0]  req_valid;
    logic [23:0] req_angle;
    logic [3:0]  req_gnt;
    logic        resp_valid;
    logic [1:0]  resp_id;
    logic [8:0]  resp_sin, resp_cos;
    logic        resp_sin_neg, resp_cos_neg;

    trig_lut_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .req_valid(req_valid), .req_angle(req_angle),
        .req_gnt(req_gnt), .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_sin(resp_sin), .resp_cos(resp_cos),
        .resp_sin_neg(resp_sin_neg), .resp_cos_neg(resp_cos_neg)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0] id;
        logic [4:0] s;
        logic [4:0] c;
        logic       sn;
        logic       cn;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [1:0] id;
        logic [5:0] ang;
        logic [4:0] s;
        logic [4:0] c;
        logic       sn;
        logic       cn;
    } vec_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   tb_ptr  = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference trig values computed from real arithmetic
    function automatic exp_t trig_model(input logic [5:0] a);
        exp_t m;
        int   r;
        real  xs, xc;
        r  = (a >= 6'd45) ? int'(a) - 45 : int'(a);
        xs = $sin(8.0 * r * 3.141592653589793 / 180.0);
        xc = $cos(8.0 * r * 3.141592653589793 / 180.0);
        if (xs < 0.0) xs = -xs;
        if (xc < 0.0) xc = -xc;
        m.s   = 5'($rtoi(16.0 * xs + 0.5));
        m.c   = 5'($rtoi(16.0 * xc + 0.5));
        m.sn  = (r >= 23);
        m.cn  = (r >= 12) && (r <= 33);
        m.id  = 2'd0;
        m.cyc = 0;
        return m;
    endfunction

    function automatic logic [8:0] fmt(input logic [4:0] m, input logic neg);
`ifdef TRIG_SIGNED_EN
        return neg ? 9'd0 - {4'd0, m} : {4'd0, m};
`else
        return {4'd0, m} | 9'(neg & 1'b0);
`endif
    endfunction

    function automatic int rr_pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Entered and left on a falling edge; one arbitration cycle
    task automatic drive_cycle(input logic [3:0] v, input logic [23:0] ang,
                               input bit ovr, input exp_t ovx, output int g);
        exp_t       e;
        logic [3:0] exp_gnt;
        req_valid = v;
        req_angle = ang;
        g = rr_pick(v, tb_ptr);
        exp_gnt = 4'd0;
        if (g >= 0) begin
            e       = ovr ? ovx : trig_model(6'(ang >> (6 * g)));
            e.id    = 2'(g);
            e.cyc   = cyc + 2;
            q.push_back(e);
            exp_gnt = 4'(1 << g);
            tb_ptr  = (g + 1) % 4;
        end
        @(negedge Clk);
        check("req_gnt", 32'(req_gnt), 32'(exp_gnt));
    endtask

    always @(negedge Clk) begin
        if (Reset_n === 1'b1 && resp_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("resp_id",      32'(resp_id),      32'(e.id));
                check("resp_sin",     32'(resp_sin),     32'(fmt(e.s, e.sn)));
                check("resp_cos",     32'(resp_cos),     32'(fmt(e.c, e.cn)));
                check("resp_sin_neg", 32'(resp_sin_neg), 32'(e.sn));
                check("resp_cos_neg", 32'(resp_cos_neg), 32'(e.cn));
                check("resp_latency", 32'(cyc),          32'(e.cyc));
            end
        end
    end

    vec_t        tbl [13];
    exp_t        ovx, dummy;
    int          g;
    logic [3:0]  pend;
    logic [23:0] angs;
    logic [23:0] all_ang;

    initial begin
        tbl[0]  = '{2'd1, 6'd0,  5'd0,  5'd16, 1'b0, 1'b0};
        tbl[1]  = '{2'd2, 6'd17, 5'd11, 5'd12, 1'b0, 1'b1};
        tbl[2]  = '{2'd3, 6'd30, 5'd14, 5'd8,  1'b1, 1'b1};
        tbl[3]  = '{2'd0, 6'd50, 5'd10, 5'd12, 1'b0, 1'b0};
        tbl[4]  = '{2'd1, 6'd5,  5'd10, 5'd12, 1'b0, 1'b0};
        tbl[5]  = '{2'd2, 6'd44, 5'd2,  5'd16, 1'b1, 1'b0};
        tbl[6]  = '{2'd3, 6'd63, 5'd9,  5'd13, 1'b0, 1'b1};
        tbl[7]  = '{2'd0, 6'd45, 5'd0,  5'd16, 1'b0, 1'b0};
        tbl[8]  = '{2'd1, 6'd12, 5'd16, 5'd2,  1'b0, 1'b1};
        tbl[9]  = '{2'd2, 6'd33, 5'd16, 5'd2,  1'b1, 1'b1};
        tbl[10] = '{2'd3, 6'd23, 5'd1,  5'd16, 1'b1, 1'b1};
        tbl[11] = '{2'd0, 6'd11, 5'd16, 5'd1,  1'b0, 1'b0};
        tbl[12] = '{2'd1, 6'd34, 5'd16, 5'd1,  1'b1, 1'b0};
        dummy   = '{2'd0, 5'd0, 5'd0, 1'b0, 1'b0, 0};
        all_ang = {6'd40, 6'd30, 6'd17, 6'd50};

        // Reset held with all requesters active
        Reset_n   = 1'b0;
        req_valid = 4'hF;
        req_angle = all_ang;
        repeat (3) @(negedge Clk);
        check("rst_req_gnt",    32'(req_gnt),      32'd0);
        check("rst_resp_valid", 32'(resp_valid),   32'd0);
        check("rst_resp_id",    32'(resp_id),      32'd0);
        check("rst_resp_sin",   32'(resp_sin),     32'd0);
        check("rst_resp_cos",   32'(resp_cos),     32'd0);
        check("rst_sin_neg",    32'(resp_sin_neg), 32'd0);
        check("rst_cos_neg",    32'(resp_cos_neg), 32'd0);
        Reset_n = 1'b1;
        tb_ptr  = 0;

        // Fairness: continuous requests give 0,1,2,3,0,...
        for (int n = 0; n < 8; n++) begin
            drive_cycle(4'hF, all_ang, 1'b0, dummy, g);
            check("fair_order", 32'(g), 32'(n % 4));
        end
        drive_cycle(4'h0, 24'd0, 1'b0, dummy, g);

        // Vector table: lone requests with hand-entered trig values
        foreach (tbl[i]) begin
            ovx = '{tbl[i].id, tbl[i].s, tbl[i].c, tbl[i].sn, tbl[i].cn, 0};
            drive_cycle(4'(1 << tbl[i].id), 24'(tbl[i].ang) << (6 * tbl[i].id), 1'b1, ovx, g);
            drive_cycle(4'h0, 24'd0, 1'b0, dummy, g);
        end

        // Lone requester back-to-back is granted every cycle
        for (int n = 0; n < 3; n++) drive_cycle(4'b0100, 24'(6'd20) << 12, 1'b0, dummy, g);
        drive_cycle(4'h0, 24'd0, 1'b0, dummy, g);

        // Random traffic honouring hold-until-grant
        pend = 4'h0;
        angs = 24'd0;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i] = 1'b1;
                    angs    = (angs & ~(24'h3F << (6 * i))) | (24'($urandom_range(63, 0)) << (6 * i));
                end
            end
            drive_cycle(pend, angs, 1'b0, dummy, g);
            if (g >= 0) pend[g] = 1'b0;
        end
        repeat (3) drive_cycle(4'h0, 24'd0, 1'b0, dummy, g);

        // Reset right after a grant: the in-flight lookup is dropped
        req_valid = 4'b0100;
        req_angle = 24'(6'd17) << 12;
        @(negedge Clk);
        check("midrst_gnt", 32'(req_gnt), 32'b0100);
        req_valid = 4'h0;
        Reset_n   = 1'b0;
        #1;
        check("midrst_gnt_clr", 32'(req_gnt), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        tb_ptr  = 0;
        for (int n = 0; n < 3; n++) begin
            check("midrst_no_resp", 32'(resp_valid), 32'd0);
            @(negedge Clk);
        end
        drive_cycle(4'hF, all_ang, 1'b0, dummy, g);
        check("midrst_ptr0", 32'(g), 32'd0);
        drive_cycle(4'h0, 24'd0, 1'b0, dummy, g);

        for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge Clk);
        check("drain_pending", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
